// File: rtl/rv_mem_pkg.sv
// Load/store type encodings shared by the decoder, control unit and data memory,
// plus the store lane-enable and data-replication helpers.
package rv_mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_t;

  typedef enum logic [1:0] {
    SB = 2'b00,
    SH = 2'b01,
    SW = 2'b10
  } store_t;

  // Encoding 2'b11 has no store type of its own and is written as a full word.
  function automatic logic [3:0] store_be(input logic [1:0] st, input logic [1:0] lane);
    logic [3:0] be;
    case (st)
      SB:      be = 4'b0001 << lane;
      SH:      be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] st, input logic [31:0] wd);
    logic [31:0] data;
    case (st)
      SB:      data = {4{wd[7:0]}};
      SH:      data = {2{wd[15:0]}};
      default: data = wd;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// Load alignment: selects the byte or half of a memory word chosen by the low
// address bits and sign- or zero-extends it according to the load type.
module rv_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  lt,
  output logic [31:0] rd
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    // Unknown load types return the whole word, like LW.
    case (lt)
      LB:      rd = {{24{byte_sel[7]}}, byte_sel};
      LBU:     rd = {24'h000000, byte_sel};
      LH:      rd = {{16{half_sel[15]}}, half_sel};
      LHU:     rd = {16'h0000, half_sel};
      default: rd = word;
    endcase
  end

endmodule

// File: rtl/rv_data_mem.sv
// RV32 data memory for the MEM stage: little-endian word array with byte-lane
// stores on the clock edge and combinational, extended loads.
module rv_data_mem
  import rv_mem_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        we,
  input  logic [1:0]  st,
  input  logic [2:0]  lt,
  input  logic [31:0] wd,
  output logic [31:0] rd
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          unused_addr_hi;

  // Upper address bits are dropped, so accesses wrap modulo the array size.
  assign widx           = a[AW+1:2];
  assign unused_addr_hi = ^a[31:AW+2];

  always_comb begin
    mem_d = mem_q;
    be    = store_be(st, a[1:0]);
    wdata = store_data(st, wd);
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_d[widx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          mem_d[widx][8*b +: 8] = mem_q[widx][8*b +: 8];
        end
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Reset clears every word at once and overrides any store on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h00000000;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  rv_load_align u_load_align (
    .word (mem_q[widx]),
    .lane (a[1:0]),
    .lt   (lt),
    .rd   (rd)
  );

endmodule

// File: tb/tb_rv_data_mem.sv
// Directed bench for rv_data_mem: stimulus tasks queue hand-computed load
// results, a negedge monitor pops and compares them against rd.
module tb_rv_data_mem;
  import rv_mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic        we;
  logic [1:0]  st;
  logic [2:0]  lt;
  logic [31:0] wd;
  logic [31:0] rd;

  logic        chk_v;
  logic [31:0] exp_q [$];
  string       name_q [$];
  int          checks;
  int          errors;

  rv_data_mem #(.DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .we  (we),
    .st  (st),
    .lt  (lt),
    .wd  (wd),
    .rd  (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every strobed cycle consumes one expected value.
  always @(negedge clk) begin
    if (chk_v) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expect: rd=%08h presented with empty scoreboard", rd);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (rd !== e) begin
          errors++;
          $display("FAIL %s: rd=%08h expected=%08h", n, rd, e);
        end
      end
    end
  end

  task automatic expect_rd(input logic [31:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_v = 1'b1;
    @(negedge clk);
    #1 chk_v = 1'b0;
  endtask

  task automatic ld(input logic [31:0] addr, input logic [2:0] t,
                    input logic [31:0] e, input string n);
    @(posedge clk);
    #1;
    a  = addr;
    lt = t;
    we = 1'b0;
    expect_rd(e, n);
  endtask

  // Store; optionally checks that rd still shows the old word before the edge.
  task automatic sto(input logic [31:0] addr, input logic [1:0] s, input logic [31:0] d,
                     input bit chk_old, input logic [31:0] old, input string n);
    @(posedge clk);
    #1;
    a  = addr;
    st = s;
    wd = d;
    we = 1'b1;
    lt = LW;
    if (chk_old) expect_rd(old, n);
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_v  = 1'b0;
    rst    = 1'b1;
    a      = 32'h00000000;
    we     = 1'b0;
    st     = SW;
    lt     = LW;
    wd     = 32'h00000000;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    ld(32'h00000000, LW, 32'h00000000, "reset_lw_0");
    ld(32'h000000FC, LW, 32'h00000000, "reset_lw_fc");

    sto(32'h00000010, SW, 32'hDEADBEEF, 1'b1, 32'h00000000, "sw_old_data");
    ld(32'h00000010, LW,  32'hDEADBEEF, "lw_10");
    ld(32'h00000010, LB,  32'hFFFFFFEF, "lb_10");
    ld(32'h00000013, LBU, 32'h000000DE, "lbu_13");
    ld(32'h00000013, LH,  32'hFFFFDEAD, "lh_13_aligned_down");
    ld(32'h00000012, LW,  32'hDEADBEEF, "lw_misaligned");
    ld(32'h00000010, 3'b111, 32'hDEADBEEF, "lt_undef_111");
    ld(32'h00000010, 3'b011, 32'hDEADBEEF, "lt_undef_011");

    sto(32'h00000022, SH, 32'h12348001, 1'b0, 32'h00000000, "");
    ld(32'h00000020, LW,  32'h80010000, "sh_word");
    ld(32'h00000022, LH,  32'hFFFF8001, "lh_22");
    ld(32'h00000022, LHU, 32'h00008001, "lhu_22");
    ld(32'h00000020, LH,  32'h00000000, "lh_20");

    sto(32'h00000030, SW, 32'h11223344, 1'b0, 32'h00000000, "");
    sto(32'h00000031, SB, 32'hAAAAAA7F, 1'b1, 32'h11223344, "sb_old_data");
    ld(32'h00000030, LW,  32'h11227F44, "sb_word");
    ld(32'h00000031, LB,  32'h0000007F, "lb_31");
    ld(32'h00000032, LBU, 32'h00000022, "lbu_32");

    sto(32'h00000040, 2'b11, 32'hCAFEF00D, 1'b0, 32'h00000000, "");
    ld(32'h00000040, LW, 32'hCAFEF00D, "st11_as_sw");
    sto(32'h00000043, SH, 32'h0000BEEF, 1'b0, 32'h00000000, "");
    ld(32'h00000040, LW, 32'hBEEFF00D, "sh_misaligned");

    // we=0 leaves memory untouched even with data on wd.
    @(posedge clk);
    #1;
    a  = 32'h00000010;
    st = SW;
    wd = 32'hFFFFFFFF;
    we = 1'b0;
    @(posedge clk);
    ld(32'h00000010, LW, 32'hDEADBEEF, "we0_no_write");
    ld(32'h00000110, LW, 32'hDEADBEEF, "alias_read");
    sto(32'h00000114, SW, 32'h0BADF00D, 1'b0, 32'h00000000, "");
    ld(32'h00000014, LW, 32'h0BADF00D, "alias_write");

    // Async reset mid-cycle: rd drops to zero before the next edge.
    @(posedge clk);
    #1;
    a  = 32'h00000010;
    lt = LW;
    we = 1'b0;
    #2 rst = 1'b1;
    expect_rd(32'h00000000, "async_rst_rd");

    // Store attempted while reset is held is dropped.
    @(posedge clk);
    #1;
    a  = 32'h00000010;
    st = SW;
    wd = 32'h55555555;
    we = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    #2 rst = 1'b0;
    ld(32'h00000010, LW, 32'h00000000, "store_in_rst_dropped");
    ld(32'h00000030, LW, 32'h00000000, "rst_cleared_30");
    ld(32'h00000040, LW, 32'h00000000, "rst_cleared_40");
    sto(32'h00000010, SW, 32'h01020304, 1'b0, 32'h00000000, "");
    ld(32'h00000010, LW, 32'h01020304, "write_after_rst");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
